// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - pipeline-side bundle for the HI/LO multiply/divide unit
//
// Purpose: groups the request, MTHI/MTLO, MFHI/MFLO hazard and result
// signals shared between the pipeline (master) and the sequencer (slave).
// Signals:
//   start, op[1:0], srcA, srcB   operation request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hi_we, lo_we, wdata          MTHI / MTLO writes
//   rd_req                       decode stage holds an MFHI/MFLO
//   busy, done, stall            sequencer status
//   hi, lo                       architectural HI/LO registers
interface muldiv_sequencer_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic            rd_req;
  logic            busy;
  logic            done;
  logic            stall;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, srcA, srcB, hi_we, lo_we, wdata, rd_req,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, hi_we, lo_we, wdata, rd_req,
    output busy, done, stall, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative radix-2 multiply/divide sequencer with HI/LO registers
//
// Purpose: 34-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle over operand magnitudes, then one sign-fix cycle that writes HI/LO.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   bus (slave) start/op/srcA/srcB, hi_we/lo_we/wdata, rd_req in;
//               busy/done/stall/hi/lo out
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;

  logic busy, done, idle_like;

  // Operand capture: signs only matter for the signed ops (op[0] == 0).
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  assign a_neg = ~bus.op[0] & bus.srcA[XLEN-1];
  assign b_neg = ~bus.op[0] & bus.srcB[XLEN-1];
  assign a_mag = a_neg ? -bus.srcA : bus.srcA;
  assign b_mag = b_neg ? -bus.srcB : bus.srcB;

  // Multiply step: {acc_hi, acc_lo} holds partial product over the
  // multiplier, which shifts out of acc_lo from the LSB.
  logic [XLEN:0] msum;
  assign msum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? a_q : '0)};

  // Divide step: acc_hi is the partial remainder, acc_lo shifts the dividend
  // out at the top and collects quotient bits at the bottom.
  logic [XLEN:0]   dshift;
  logic            dfit;
  logic [XLEN-1:0] dsub;
  assign dshift = {acc_hi_q, acc_lo_q[XLEN-1]};
  assign dfit   = dshift >= {1'b0, b_q};
  assign dsub   = dshift[XLEN-1:0] - b_q;  // exact: true difference is below 2^XLEN

  // Sign fix. A zero divisor never sets quotient sign, so lo stays all-ones
  // while the remainder (the full dividend magnitude) regains srcA's sign.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  assign prod_fix = (sa_q ^ sb_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign quo_fix  = (b_q == '0) ? '1 : ((sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q);
  assign rem_fix  = sa_q ? -acc_hi_q : acc_hi_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (cnt_q == 6'(XLEN - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q == S_RUN) || (state_q == S_FIX);
    done      = (state_q == S_DONE);
    idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.stall = bus.rd_req & busy;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // Datapath next state
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (idle_like) begin
      if (bus.hi_we) hi_d = bus.wdata;
      if (bus.lo_we) lo_d = bus.wdata;
      if (bus.start) begin
        op_d     = bus.op;
        sa_d     = a_neg;
        sb_d     = b_neg;
        a_d      = a_mag;
        b_d      = b_mag;
        cnt_d    = '0;
        acc_hi_d = '0;
        acc_lo_d = bus.op[1] ? a_mag : b_mag;
      end
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q + 6'd1;
      if (op_q[1]) begin
        acc_hi_d = dfit ? dsub : dshift[XLEN-1:0];
        acc_lo_d = {acc_lo_q[XLEN-2:0], dfit};
      end else begin
        acc_hi_d = msum[XLEN:1];
        acc_lo_d = {msum[0], acc_lo_q[XLEN-1:1]};
      end
    end else if (state_q == S_FIX) begin
      if (op_q[1]) begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end else begin
        {hi_d, lo_d} = prod_fix;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - table-driven and directed checks for muldiv_sequencer
module tb_muldiv_sequencer;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.XLEN(32)) bus();
  muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec  = 0;
  int nfail = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op at the current (post-negedge) time and follow it to done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output int busy_cyc,
                        output logic [31:0] rhi, output logic [31:0] rlo);
    bus.start = 1'b1;
    bus.op    = op;
    bus.srcA  = a;
    bus.srcB  = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    done_cyc = 0;
    busy_cyc = 0;
    rhi = '0;
    rlo = '0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_cyc = c;
        rhi = bus.hi;
        rlo = bus.lo;
      end
    end
  endtask

  int          dc, bc, sc, stall_at_done;
  logic [31:0] rh, rl;

  initial begin
    vt[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[1]  = '{MULT,  -32'sd10000,  32'd10000,    32'hFFFFFFFF, 32'hFA0A1F00};
    vt[2]  = '{DIV,   -32'sd7,      32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vt[4]  = '{DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vt[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[6]  = '{MULT,  32'd7,        -32'sd3,      32'hFFFFFFFF, 32'hFFFFFFEB};
    vt[7]  = '{DIV,   32'd7,        -32'sd2,      32'd1,        32'hFFFFFFFD};
    vt[8]  = '{DIV,   -32'sd7,      32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vt[9]  = '{MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vt[10] = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
    vt[11] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[12] = '{DIV,   -32'sd100,    -32'sd7,      32'hFFFFFFFE, 32'd14};

    rst = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.srcA = '0; bus.srcB = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0; bus.rd_req = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("reset busy",  64'(bus.busy),  64'd0);
    check("reset done",  64'(bus.done),  64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);
    check("reset hi",    64'(bus.hi),    64'd0);
    check("reset lo",    64'(bus.lo),    64'd0);
    rst = 1'b1;

    // MTHI / MTLO in IDLE, then hold
    @(negedge clk);
    check("idle stall", 64'(bus.stall), 64'd0);
    bus.hi_we = 1'b1; bus.wdata = 32'hAAAA5555;
    @(posedge clk); #1 bus.hi_we = 1'b0;
    @(negedge clk);
    check("mthi hi", 64'(bus.hi), 64'hAAAA5555);
    check("mthi lo", 64'(bus.lo), 64'h0);
    bus.lo_we = 1'b1; bus.wdata = 32'h5555AAAA;
    @(posedge clk); #1 bus.lo_we = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("hold hi", 64'(bus.hi), 64'hAAAA5555);
    check("hold lo", 64'(bus.lo), 64'h5555AAAA);
    bus.rd_req = 1'b0;

    // Table: each op after the first is started from DONE
    for (int i = 0; i < 13; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, dc, bc, rh, rl);
      check($sformatf("v%0d done cycle", i), 64'(dc), 64'd34);
      check($sformatf("v%0d busy cycles", i), 64'(bc), 64'd33);
      check($sformatf("v%0d hi", i), 64'(rh), 64'(vt[i].ehi));
      check($sformatf("v%0d lo", i), 64'(rl), 64'(vt[i].elo));
    end
    @(negedge clk);
    check("done pulse width", 64'(bus.done), 64'd0);
    check("back to idle busy", 64'(bus.busy), 64'd0);

    // Start together with MTHI: write lands now, result overwrites later
    bus.hi_we = 1'b1; bus.wdata = 32'h11111111;
    bus.start = 1'b1; bus.op = DIVU; bus.srcA = 32'd100; bus.srcB = 32'd7;
    @(posedge clk); #1 bus.start = 1'b0; bus.hi_we = 1'b0;
    @(negedge clk);
    check("start+mthi hi", 64'(bus.hi), 64'h11111111);
    check("start+mthi busy", 64'(bus.busy), 64'd1);
    dc = 0;
    for (int c = 2; c <= 40 && dc == 0; c++) begin
      @(negedge clk);
      if (bus.done) dc = c;
    end
    check("start+mthi done cycle", 64'(dc), 64'd34);
    check("start+mthi result", {bus.hi, bus.lo}, {32'd2, 32'd14});

    // Ignored restart, dropped MTHI, stall while busy
    bus.rd_req = 1'b1;
    bus.start = 1'b1; bus.op = DIVU; bus.srcA = 32'd1000; bus.srcB = 32'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    dc = 0; sc = 0; stall_at_done = 1;
    for (int c = 1; c <= 40 && dc == 0; c++) begin
      @(negedge clk);
      if (bus.done) begin
        dc = c;
        stall_at_done = int'(bus.stall);
      end else if (bus.stall) sc++;
      if (c == 5) begin
        bus.start = 1'b1; bus.op = MULTU; bus.srcA = 32'hFFFFFFFF; bus.srcB = 32'hFFFFFFFF;
      end
      if (c == 6) bus.start = 1'b0;
      if (c == 8) begin bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF; end
      if (c == 9) bus.hi_we = 1'b0;
    end
    check("restart done cycle", 64'(dc), 64'd34);
    check("restart stall cycles", 64'(sc), 64'd33);
    check("restart stall at done", 64'(stall_at_done), 64'd0);
    check("restart result", {bus.hi, bus.lo}, {32'd1, 32'd333});
    @(negedge clk);
    check("restart idle busy", 64'(bus.busy), 64'd0);
    check("restart hold", {bus.hi, bus.lo}, {32'd1, 32'd333});

    // Reset mid-RUN aborts; first edge after release accepts start
    bus.start = 1'b1; bus.op = MULTU; bus.srcA = 32'd9; bus.srcB = 32'd9;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort busy",  64'(bus.busy),  64'd0);
    check("abort done",  64'(bus.done),  64'd0);
    check("abort stall", 64'(bus.stall), 64'd0);
    check("abort hilo",  {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.rd_req = 1'b0;
    run_op(MULTU, 32'd3, 32'd4, dc, bc, rh, rl);
    check("post-reset done cycle", 64'(dc), 64'd34);
    check("post-reset result", {rh, rl}, {32'd0, 32'd12});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request an operation; sampled on clk.
REQ-005 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port srcA  input  32  multiplicand / dividend.
REQ-007 SHALL have port srcB  input  32  multiplier / divisor.
REQ-008 SHALL have port hi_we, lo_we  input  1 each  MTHI / MTLO write enables.
REQ-009 SHALL have port wdata  input  32  MTHI/MTLO write data.
REQ-010 SHALL have port rd_req  input  1  decode stage holds an MFHI/MFLO.
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port stall  output  1  pipeline hold request.
REQ-014 SHALL have port hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-016 SHALL accept start only in IDLE or DONE: at edge E0, latch operand magnitudes, operand signs (signed ops only) and op, zero a 6-bit iteration counter, and enter RUN.
REQ-017 SHALL ignore start in RUN and FIX; latched operands SHALL be unaffected.
REQ-018 SHALL in RUN perform one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide) over magnitudes; after the 32nd step (edge E32) it SHALL enter FIX.
REQ-019 SHALL at E33 (FIX) apply sign correction, write hi/lo, and enter DONE.
REQ-020 SHALL in DONE drive done=1 for exactly one cycle, then return to IDLE at E34 unless start is accepted.
REQ-021 SHALL assert busy exactly while in RUN or FIX (cycles after E0 through E33); total latency from start edge to done high SHALL be 34 cycles.
REQ-022 SHALL produce for MULT/MULTU the full 64-bit two's-complement/unsigned product: {hi,lo}.
REQ-023 SHALL produce for DIV/DIVU lo=quotient and hi=remainder; DIV quotient truncates toward zero and its remainder takes the sign of the dividend.
REQ-024 SHALL on divisor 0 still use the full 34-cycle latency, with lo=32'hFFFFFFFF and hi=srcA as latched.
REQ-025 SHALL for DIV 32'h80000000 / 32'hFFFFFFFF produce lo=32'h80000000, hi=0 without error.
REQ-026 SHALL drive stall = rd_req & busy combinationally; stall SHALL be 0 in DONE, where hi/lo are already valid.
REQ-027 SHALL, when hi_we/lo_we are high in IDLE or DONE, write wdata into hi/lo at that edge.
REQ-028 SHALL drop hi_we/lo_we while busy.
REQ-029 SHALL, when start and an MT write coincide in IDLE or DONE, perform both; the operation result later overwrites hi/lo.
REQ-030 SHALL leave hi/lo unchanged between writes.

Reset
REQ-031 SHALL, on rst low, immediately force state IDLE, busy=0, done=0, hi=0, lo=0 and counter=0; stall follows busy and is therefore 0.
REQ-032 SHALL abort an in-flight operation when rst asserts in RUN/FIX; no partial result SHALL reach hi/lo.
REQ-033 SHALL accept start on the first rising edge after rst deasserts.

Verification
REQ-034 SHALL pass: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy 33 cycles; done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 SHALL pass: MULT -10000 x 10000 -> hi=0xFFFFFFFF, lo=0xFA0A1F00.
REQ-036 SHALL pass:
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 7 -> lo=14, hi=2.
REQ-037 SHALL pass:
- DIVU 5 / 0 -> hi=5, lo=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 SHALL pass: start pulsed again at RUN cycle 5, rd_req held high, and hi_we at cycle 8 -> second start ignored, write dropped, stall=1 through cycle 33, stall=0 when done=1, and the original result is intact.
REQ-039 SHALL pass: rst low at RUN cycle 10 -> busy=0, done=0, hi=lo=0 immediately; a subsequent MULTU 3 x 4 -> lo=12, hi=0 at cycle 34.
